// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad one column at a time, synchronises
// and debounces every key, and presents the debounced state as keyMatrix
// together with one-cycle press/release events.
// Optional build macro: KEYPAD_REMAP_EN (maps physical keys to CHIP-8 layout).
module keypad_scanner #(
   parameter int SETTLE_CYCLES  = 8,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scan_en,
   input  logic [3:0]  row_n,
   output logic [3:0]  col_n,
   output logic [15:0] keyMatrix,
   output logic        key_event,
   output logic [3:0]  key_code,
   output logic        key_down
);

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, COMMIT} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] DB_LAST     = 4'(DEBOUNCE_SCANS - 1);

   // Physical index p = col*4 + row to reported hex code.
   function automatic logic [3:0] map_key(input logic [3:0] p);
`ifdef KEYPAD_REMAP_EN
      case (p)
         4'd0:    map_key = 4'h1;
         4'd1:    map_key = 4'h4;
         4'd2:    map_key = 4'h7;
         4'd3:    map_key = 4'hA;
         4'd4:    map_key = 4'h2;
         4'd5:    map_key = 4'h5;
         4'd6:    map_key = 4'h8;
         4'd7:    map_key = 4'h0;
         4'd8:    map_key = 4'h3;
         4'd9:    map_key = 4'h6;
         4'd10:   map_key = 4'h9;
         4'd11:   map_key = 4'hB;
         4'd12:   map_key = 4'hC;
         4'd13:   map_key = 4'hD;
         4'd14:   map_key = 4'hE;
         default: map_key = 4'hF;
      endcase
`else
      map_key = p;
`endif
   endfunction

   state_t           state, state_nxt;
   logic [1:0]       col, col_nxt;
   logic [7:0]       cnt, cnt_nxt;
   logic [3:0]       k, k_nxt;
   logic [3:0]       col_n_nxt;
   logic [15:0]      raw, raw_nxt;
   logic [15:0]      stable, stable_nxt;
   logic [15:0][3:0] dbc, dbc_nxt;
   logic [15:0]      km_nxt;
   logic             key_event_nxt;
   logic [3:0]       key_code_nxt;
   logic             key_down_nxt;
   logic [3:0]       row_meta, row_sync;

   // Two-flop synchroniser for the asynchronous row inputs; idles at "row high".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row_n;
         row_sync <= row_meta;
      end
   end

   // Next-state and datapath updates for the scan / debounce sequencer.
   always_comb begin
      state_nxt     = state;
      col_nxt       = col;
      cnt_nxt       = cnt;
      k_nxt         = k;
      col_n_nxt     = col_n;
      raw_nxt       = raw;
      stable_nxt    = stable;
      dbc_nxt       = dbc;
      km_nxt        = keyMatrix;
      key_event_nxt = 1'b0;
      key_code_nxt  = key_code;
      key_down_nxt  = key_down;
      case (state)
         IDLE: begin
            col_n_nxt = 4'hF;
            if (scan_en) begin
               state_nxt = DRIVE;
               col_nxt   = 2'd0;
            end
         end
         DRIVE: begin
            col_n_nxt = ~(4'b0001 << col);
            cnt_nxt   = 8'd0;
            state_nxt = SETTLE;
         end
         SETTLE: begin
            cnt_nxt = cnt + 8'd1;
            if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            raw_nxt[{col, 2'b00} +: 4] = ~row_sync;
            if (col == 2'd3) begin
               col_n_nxt = 4'hF;
               k_nxt     = 4'd0;
               state_nxt = COMMIT;
            end else begin
               col_nxt   = col + 2'd1;
               state_nxt = DRIVE;
            end
         end
         COMMIT: begin
            // One key per cycle, so simultaneous changes become separate events.
            if (raw[k] == stable[k]) begin
               dbc_nxt[k] = 4'd0;
            end else if (dbc[k] == DB_LAST) begin
               stable_nxt[k]       = raw[k];
               dbc_nxt[k]          = 4'd0;
               km_nxt[map_key(k)]  = raw[k];
               key_event_nxt       = 1'b1;
               key_code_nxt        = map_key(k);
               key_down_nxt        = raw[k];
            end else begin
               dbc_nxt[k] = dbc[k] + 4'd1;
            end
            k_nxt = k + 4'd1;
            if (k == 4'd15) begin
               if (scan_en) begin
                  state_nxt = DRIVE;
                  col_nxt   = 2'd0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any scan in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         col       <= 2'd0;
         cnt       <= 8'd0;
         k         <= 4'd0;
         col_n     <= 4'hF;
         raw       <= 16'h0000;
         stable    <= 16'h0000;
         dbc       <= '0;
         keyMatrix <= 16'h0000;
         key_event <= 1'b0;
         key_code  <= 4'h0;
         key_down  <= 1'b0;
      end else begin
         state     <= state_nxt;
         col       <= col_nxt;
         cnt       <= cnt_nxt;
         k         <= k_nxt;
         col_n     <= col_n_nxt;
         raw       <= raw_nxt;
         stable    <= stable_nxt;
         dbc       <= dbc_nxt;
         keyMatrix <= km_nxt;
         key_event <= key_event_nxt;
         key_code  <= key_code_nxt;
         key_down  <= key_down_nxt;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: keypad matrix model, scan-level reference
// model feeding an event scoreboard, and an independent output monitor.
module tb_keypad_scanner;

   localparam int S      = 3;
   localparam int D      = 2;
   localparam int PERIOD = 4 * (S + 2) + 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        scan_en = 1'b0;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [15:0] keyMatrix;
   logic        key_event;
   logic [3:0]  key_code;
   logic        key_down;

   logic [15:0] pressed = 16'h0000;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          p;
      logic [3:0]  code;
      logic        down;
      logic [15:0] km;
   } ev_t;
   ev_t exp_q[$];

   logic [15:0] m_stable = 16'h0000;
   logic [15:0] m_km     = 16'h0000;
   int          m_run[16];

   int layout [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

   keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
      .clk(clk), .reset(reset), .scan_en(scan_en), .row_n(row_n), .col_n(col_n),
      .keyMatrix(keyMatrix), .key_event(key_event), .key_code(key_code), .key_down(key_down)
   );

   always #5 clk = ~clk;

   // Keypad: a closed key pulls its row low while its column is driven low.
   always_comb begin
      row_n = 4'hF;
      for (int c = 0; c < 4; c++)
         if (!col_n[c])
            for (int r = 0; r < 4; r++)
               if (pressed[c * 4 + r]) row_n[r] = 1'b0;
   end

   function automatic int hex_of(input int p);
`ifdef KEYPAD_REMAP_EN
      return layout[p % 4][p / 4];
`else
      return p;
`endif
   endfunction

   function automatic logic [3:0] next_col(input logic [3:0] c);
      case (c)
         4'hF:    return 4'hE;
         4'hE:    return 4'hD;
         4'hD:    return 4'hB;
         4'hB:    return 4'h7;
         default: return 4'hF;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A key's debounced state flips once it has been seen opposite for D scans in a row.
   task automatic model_scan(input logic [15:0] v);
      ev_t e;
      for (int p = 0; p < 16; p++) begin
         if (v[p] == m_stable[p]) begin
            m_run[p] = 0;
         end else begin
            m_run[p] = m_run[p] + 1;
            if (m_run[p] == D) begin
               m_run[p]          = 0;
               m_stable[p]       = v[p];
               m_km[hex_of(p)]   = v[p];
               e.p    = p;
               e.code = 4'(hex_of(p));
               e.down = v[p];
               e.km   = m_km;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic model_reset();
      m_stable = 16'h0000;
      m_km     = 16'h0000;
      for (int p = 0; p < 16; p++) m_run[p] = 0;
      exp_q.delete();
   endtask

   // Hold v for one full scan; returns in the first cycle after the scan's last sample.
   task automatic run_scan(input logic [15:0] v, input bit drop);
      logic [3:0] prev;
      bit         done;
      pressed = v;
      scan_en = 1'b1;
      if (drop) begin
         for (int i = 0; i < 400 && col_n != 4'hD; i++) @(negedge clk);
         scan_en = 1'b0;
      end
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         prev = col_n;
         @(negedge clk);
         if (prev == 4'h7 && col_n == 4'hF) done = 1'b1;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scan_timeout: got no scan end, expected one within 400 cycles");
      end else begin
         check("km_at_scan_end", keyMatrix, m_km);
         model_scan(v);
      end
   endtask

   // Monitor: column sequence, scan period, and scoreboard of key events.
   int          cyc = 0;
   int          f_cnt = 100;
   int          last_e = 0;
   bit          have_e = 1'b0;
   logic [3:0]  prev_col = 4'hF;
   always @(negedge clk) begin
      ev_t e;
      cyc++;
      if (reset) begin
         prev_col = 4'hF;
         f_cnt    = 100;
         have_e   = 1'b0;
      end else begin
         if (col_n != prev_col) begin
            check("col_seq", col_n, next_col(prev_col));
            if (col_n == 4'hE) begin
               if (have_e && f_cnt == 16) check("scan_period", cyc - last_e, PERIOD);
               have_e = 1'b1;
               last_e = cyc;
            end
            if (col_n == 4'hF) f_cnt = 0;
         end else if (col_n == 4'hF && f_cnt < 100000) begin
            f_cnt++;
         end
         if (key_event) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_event: got key_code %0h down %0b, expected no event", key_code, key_down);
            end else begin
               e = exp_q.pop_front();
               check("ev_code", key_code, e.code);
               check("ev_down", key_down, e.down);
               check("ev_matrix", keyMatrix, e.km);
               check("ev_timing", f_cnt, e.p + 1);
            end
         end
         prev_col = col_n;
      end
   end

   initial begin
      logic [15:0] v;
      model_reset();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_col_n", col_n, 4'hF);
         check("rst_matrix", keyMatrix, 16'h0000);
         check("rst_event", key_event, 1'b0);
         check("rst_code", key_code, 4'h0);
         check("rst_down", key_down, 1'b0);
      end
      reset = 1'b0;

      // Idle keypad: ten scans without any event.
      for (int i = 0; i < 10; i++) run_scan(16'h0000, 1'b0);
      check("idle_matrix", keyMatrix, 16'h0000);

      // Single key row 1 col 2 pressed then released.
      for (int i = 0; i < 3; i++) run_scan(16'h0200, 1'b0);
      check("p9_matrix", keyMatrix, 32'(1) << hex_of(9));
      for (int i = 0; i < 3; i++) run_scan(16'h0000, 1'b0);
      check("p9_released", keyMatrix, 16'h0000);

      // Bounce: present for a single scan only.
      run_scan(16'h0020, 1'b0);
      for (int i = 0; i < 3; i++) run_scan(16'h0000, 1'b0);
      check("bounce_matrix", keyMatrix, 16'h0000);

      // Lowest and highest physical keys together.
      for (int i = 0; i < 3; i++) run_scan(16'h8001, 1'b0);
      check("p0_p15_matrix", keyMatrix, (32'(1) << hex_of(0)) | (32'(1) << hex_of(15)));
      for (int i = 0; i < 3; i++) run_scan(16'h0000, 1'b0);

      // Keys at row 3 col 1 and row 0 col 3 (hex 0 and C under remap).
      for (int i = 0; i < 3; i++) run_scan(16'h1080, 1'b0);
      check("p7_p12_matrix", keyMatrix, (32'(1) << hex_of(7)) | (32'(1) << hex_of(12)));
      for (int i = 0; i < 3; i++) run_scan(16'h0000, 1'b0);

      // Randomised key activity with occasional one-scan glitches.
      v = 16'h0000;
      for (int i = 0; i < 30; i++) begin
         v = v ^ 16'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 3) == 0) run_scan(v ^ 16'(32'(1) << $urandom_range(0, 15)), 1'b0);
         else run_scan(v, 1'b0);
      end

      // scan_en dropped in column 1: scan and commit finish, then idle.
      run_scan(v, 1'b0);
      run_scan(16'h4422, 1'b0);
      run_scan(16'h4422, 1'b1);
      for (int i = 0; i < 60; i++) @(negedge clk);
      check("idle_col_n", col_n, 4'hF);
      check("idle_held_matrix", keyMatrix, m_km);

      // Reset pulsed mid-SETTLE with keys committed.
      run_scan(16'h4422, 1'b0);
      run_scan(16'h4422, 1'b0);
      for (int i = 0; i < 400 && col_n != 4'hE; i++) @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_col_n", col_n, 4'hF);
      check("midrst_matrix", keyMatrix, 16'h0000);
      check("midrst_event", key_event, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         v = v ^ 16'($urandom & $urandom);
         run_scan(v, 1'b0);
      end
      run_scan(v, 1'b0);
      run_scan(v, 1'b0);

      for (int i = 0; i < 20; i++) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_matrix", keyMatrix, m_km);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
